// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
//   Bundles every non-clock/reset signal of alu_sequencer: the instruction
//   handshake, status pulses, the debug register read port and the external
//   ALU bus.
//
//   slave  : sequencer side (accepts instructions, drives the ALU bus)
//   master : environment side (issues instructions, models the ALU)
//
//   instr_valid / instr_ready / instr : instruction handshake (16-bit word)
//   busy / done / err                 : status (done, err are 1-cycle pulses)
//   rd_addr / rd_data                 : combinational debug register read
//   alu_en / alu_oper / alu_a / alu_b : ALU issue strobe and operands
//   alu_q                             : ALU result, registered when alu_en=1
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        alu_en;
  logic [3:0]  alu_oper;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_q;

  modport slave (
    input  instr_valid, instr, rd_addr, alu_q,
    output instr_ready, busy, done, err, rd_data,
           alu_en, alu_oper, alu_a, alu_b
  );

  modport master (
    output instr_valid, instr, rd_addr, alu_q,
    input  instr_ready, busy, done, err, rd_data,
           alu_en, alu_oper, alu_a, alu_b
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Single-issue sequencer in front of an external registered ALU. Holds an
//   8 x 16 register file. Instruction word: [15:12] op, [11:9] rd,
//   [8:6] rsa, [5:3] rsb; for LDI the immediate is [8:0].
//     op 1..10 : ALU op   IDLE -> ISSUE -> WB -> IDLE, R[rd] <= alu_q
//     op 0     : NOP      IDLE -> WB -> IDLE, no write
//     op 11    : LDI      IDLE -> WB -> IDLE, R[rd] <= {7'b0, imm9}
//     op 12..15: illegal  IDLE -> WB -> IDLE, no write, err with done
//
//   Ports:
//     clk : clock, all state changes on posedge
//     rst : synchronous, active-high reset
//     bus : alu_sequencer_if.slave (handshake, status, debug read, ALU bus)
// ---------------------------------------------------------------------------
module alu_sequencer (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI = 4'd11;

  state_t      state;
  state_t      state_next;
  logic [15:0] instr_q;
  logic [15:0] regs [8];

  logic        accept;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        done_w;
  logic        err_w;

  // Fields of the latched word; the input word may change after acceptance.
  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rsa;
  logic [2:0] rsb;
  logic [8:0] imm;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:9];
  assign rsa = instr_q[8:6];
  assign rsb = instr_q[5:3];
  assign imm = instr_q[8:0];

  function automatic logic is_alu_op(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd10);
  endfunction

  // NOTE: state and storage use non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      // NOTE: the register file is only eight flops deep and must read as zero
      // after reset, so it is cleared here rather than left as an unreset RAM.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) instr_q <= bus.instr;
      if (wr_en) regs[rd] <= wr_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    wr_en           = 1'b0;
    wr_data         = '0;
    done_w          = 1'b0;
    err_w           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.busy        = 1'b0;
    bus.alu_en      = 1'b0;
    bus.alu_oper    = '0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;

    unique case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept     = 1'b1;
          // Decode the incoming word: only ALU ops need an ISSUE cycle.
          state_next = is_alu_op(bus.instr[15:12]) ? ISSUE : WB;
        end
      end
      ISSUE: begin
        bus.busy     = 1'b1;
        bus.alu_en   = 1'b1;
        bus.alu_oper = op;
        bus.alu_a    = regs[rsa];
        bus.alu_b    = regs[rsb];
        state_next   = WB;
      end
      WB: begin
        bus.busy   = 1'b1;
        done_w     = 1'b1;
        err_w      = (op >= 4'd12);
        wr_en      = is_alu_op(op) || (op == OP_LDI);
        wr_data    = is_alu_op(op) ? bus.alu_q : {7'b0, imm};
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A reset landing in WB aborts the instruction, so the pulse is suppressed.
  assign bus.done    = done_w & ~rst;
  assign bus.err     = err_w & ~rst;
  assign bus.rd_data = regs[bus.rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. Provides a behavioural registered
//   ALU and an instruction-level reference model of the register file; all
//   expected values come from that model or from constants.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [15:0] model_regs [8];

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [3:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      4'd1:    return b + a;
      4'd2:    return b - a;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a >> b;
      4'd7:    return a << b;
      4'd8:    return {a[0], a[15:1]};
      4'd9:    return a;
      4'd10:   return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  // External ALU: result registered on the edge where alu_en is high.
  always @(posedge clk) begin
    if (rst) bus.alu_q <= 16'h0000;
    else if (bus.alu_en) bus.alu_q <= alu_fn(bus.alu_oper, bus.alu_a, bus.alu_b);
  end

  function automatic logic [15:0] enc_alu(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rsa, input logic [2:0] rsb);
    return {op, rd, rsa, rsb, 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'd11, rd, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
  endtask

  // Reads all eight registers through the debug port against the model.
  task automatic check_all_regs(input string tag);
    step();
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      #1;
      n_checks++;
      if (bus.rd_data !== model_regs[i]) begin
        n_errors++;
        $display("FAIL %s R%0d: got %h expected %h", tag, i, bus.rd_data, model_regs[i]);
      end
    end
  endtask

  // Issues one instruction and checks every cycle until the sequencer is idle
  // again, then checks the destination register through the debug port.
  task automatic exec_instr(input logic [15:0] w);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        is_alu;
    logic        is_ill;
    int          guard;
    op     = w[15:12];
    rd     = w[11:9];
    ra     = model_regs[w[8:6]];
    rb     = model_regs[w[5:3]];
    is_alu = (op >= 4'd1) && (op <= 4'd10);
    is_ill = (op >= 4'd12);

    guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 10) begin
      n_errors++;
      $display("FAIL ready_timeout: instr_ready never rose for word %h", w);
      return;
    end

    bus.instr_valid = 1'b1;
    bus.instr       = w;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    #1;

    if (is_alu) begin
      // ISSUE cycle: {ready,busy,done,err,alu_en}
      n_checks++;
      if ({bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== 5'b01001) begin
        n_errors++;
        $display("FAIL issue_ctrl word %h: got %b expected 01001", w,
                 {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en});
      end
      n_checks++;
      if ({bus.alu_oper, bus.alu_a, bus.alu_b} !== {op, ra, rb}) begin
        n_errors++;
        $display("FAIL issue_operands word %h: got op=%h a=%h b=%h expected op=%h a=%h b=%h",
                 w, bus.alu_oper, bus.alu_a, bus.alu_b, op, ra, rb);
      end
      step();
      n_checks++;
      if ({bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== 5'b01100) begin
        n_errors++;
        $display("FAIL wb_ctrl word %h: got %b expected 01100", w,
                 {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en});
      end
      n_checks++;
      if ({bus.alu_oper, bus.alu_a, bus.alu_b} !== 36'h0) begin
        n_errors++;
        $display("FAIL wb_alu_bus_idle word %h: got op=%h a=%h b=%h expected zeros",
                 w, bus.alu_oper, bus.alu_a, bus.alu_b);
      end
      model_regs[rd] = alu_fn(op, ra, rb);
    end else begin
      n_checks++;
      if ({bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== {4'b0110, is_ill, 1'b0} >> 0 ?
          {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== {3'b011, is_ill, 1'b0} : 1'b0) begin
        n_errors++;
        $display("FAIL direct_wb_ctrl word %h: got %b expected %b", w,
                 {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en}, {3'b011, is_ill, 1'b0});
      end
      n_checks++;
      if ({bus.alu_oper, bus.alu_a, bus.alu_b} !== 36'h0) begin
        n_errors++;
        $display("FAIL direct_wb_alu_bus word %h: got op=%h a=%h b=%h expected zeros",
                 w, bus.alu_oper, bus.alu_a, bus.alu_b);
      end
      if (op == 4'd11) model_regs[rd] = {7'b0, w[8:0]};
    end

    step();
    n_checks++;
    if ({bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== 5'b10000) begin
      n_errors++;
      $display("FAIL back_idle word %h: got %b expected 10000", w,
               {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en});
    end
    bus.rd_addr = rd;
    #1;
    n_checks++;
    if (bus.rd_data !== model_regs[rd]) begin
      n_errors++;
      $display("FAIL dest_reg word %h R%0d: got %h expected %h", w, rd, bus.rd_data, model_regs[rd]);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = enc_ldi(3'd1, 9'h1AB);
    step();
    step();
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if ({bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en});
    end
    n_checks++;
    if ({bus.alu_oper, bus.alu_a, bus.alu_b} !== 36'h0) begin
      n_errors++;
      $display("FAIL reset_alu_bus: got op=%h a=%h b=%h expected zeros",
               bus.alu_oper, bus.alu_a, bus.alu_b);
    end
    step();
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_no_accept: instr_ready got %b expected 1", bus.instr_ready);
    end
    check_all_regs("reset_regs");
  endtask

  task automatic test_directed();
    exec_instr(enc_ldi(3'd1, 9'h005));
    exec_instr(enc_ldi(3'd2, 9'h003));
    exec_instr(enc_alu(4'd1, 3'd3, 3'd1, 3'd2));
    bus.rd_addr = 3'd3;
    #1;
    n_checks++;
    if (bus.rd_data !== 16'h0008) begin
      n_errors++;
      $display("FAIL add_r3: got %h expected 0008", bus.rd_data);
    end
    exec_instr(enc_alu(4'd2, 3'd4, 3'd1, 3'd2));
    bus.rd_addr = 3'd4;
    #1;
    n_checks++;
    if (bus.rd_data !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL sub_r4: got %h expected fffe", bus.rd_data);
    end
    exec_instr(enc_alu(4'd10, 3'd5, 3'd4, 3'd0));
    bus.rd_addr = 3'd5;
    #1;
    n_checks++;
    if (bus.rd_data !== 16'h0001) begin
      n_errors++;
      $display("FAIL not_r5: got %h expected 0001", bus.rd_data);
    end
    exec_instr(enc_ldi(3'd6, 9'h1FF));
    exec_instr(enc_alu(4'd1, 3'd6, 3'd6, 3'd6));
    bus.rd_addr = 3'd6;
    #1;
    n_checks++;
    if (bus.rd_data !== 16'h03FE) begin
      n_errors++;
      $display("FAIL dbl_r6: got %h expected 03fe", bus.rd_data);
    end
    exec_instr(enc_alu(4'd1, 3'd6, 3'd6, 3'd6));
    bus.rd_addr = 3'd6;
    #1;
    n_checks++;
    if (bus.rd_data !== 16'h07FC) begin
      n_errors++;
      $display("FAIL dep_r6: got %h expected 07fc", bus.rd_data);
    end
    check_all_regs("directed_regs");
  endtask

  task automatic test_illegal_nop();
    exec_instr(16'hC000);
    exec_instr({4'd15, 12'($urandom)});
    exec_instr(16'h0000);
    exec_instr({4'd0, 12'($urandom)});
    check_all_regs("illegal_nop_regs");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) exec_instr(enc_ldi(3'(i), 9'($urandom)));
    for (int n = 0; n < 40; n++) exec_instr(16'($urandom));
    check_all_regs("random_regs");
  endtask

  task automatic test_reset_abort();
    exec_instr(enc_ldi(3'd1, 9'h005));
    bus.instr_valid = 1'b1;
    bus.instr       = enc_alu(4'd1, 3'd7, 3'd1, 3'd2);
    step();
    bus.instr_valid = 1'b0;
    n_checks++;
    if (bus.alu_en !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_issue: alu_en got %b expected 1", bus.alu_en);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_done_issue: done got %b expected 0", bus.done);
    end
    step();
    rst = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if ({bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en} !== 5'b10000) begin
      n_errors++;
      $display("FAIL abort_after_reset: got %b expected 10000",
               {bus.instr_ready, bus.busy, bus.done, bus.err, bus.alu_en});
    end
    step();
    n_checks++;
    if ({bus.instr_ready, bus.done} !== 2'b10) begin
      n_errors++;
      $display("FAIL abort_no_done: ready/done got %b expected 10", {bus.instr_ready, bus.done});
    end
    check_all_regs("abort_regs");
  endtask

  // instr_valid held high with a fresh word every cycle; the model predicts
  // which words are accepted from instruction latencies alone.
  task automatic test_back_to_back();
    int          left;
    int          accepted;
    logic        exp_err;
    logic [15:0] w;
    logic [3:0]  op;
    left     = 0;
    accepted = 0;
    exp_err  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      w               = 16'($urandom);
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      #1;
      n_checks++;
      if ({bus.instr_ready, bus.done, bus.err} !==
          {(left == 0), (left == 1), (left == 1) && exp_err}) begin
        n_errors++;
        $display("FAIL b2b_cycle%0d: ready/done/err got %b expected %b", c,
                 {bus.instr_ready, bus.done, bus.err},
                 {(left == 0), (left == 1), (left == 1) && exp_err});
      end
      if (left == 0) begin
        op = w[15:12];
        accepted++;
        exp_err = (op >= 4'd12);
        if (op >= 4'd1 && op <= 4'd10) begin
          model_regs[w[11:9]] = alu_fn(op, model_regs[w[8:6]], model_regs[w[5:3]]);
          left = 2;
        end else begin
          if (op == 4'd11) model_regs[w[11:9]] = {7'b0, w[8:0]};
          left = 1;
        end
      end else begin
        left--;
      end
      @(posedge clk);
      #1;
    end
    bus.instr_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (accepted < 15) begin
      n_errors++;
      $display("FAIL b2b_accept_count: got %0d expected at least 15", accepted);
    end
    check_all_regs("b2b_regs");
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.rd_addr     = 3'd0;
    clear_model();

    test_reset();
    test_directed();
    test_illegal_nop();
    test_random();
    test_reset_abort();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
